// File: rtl/mips_mem_pkg.sv
// Shared types and sizes for the data-memory port arbiter.
package mips_mem_pkg;
    localparam int DMEM_ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        RUN,
        HALT_REQ,
        HALT
    } arb_state_t;
endpackage

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating count of denied debug-request cycles; raises starved at the limit.
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved = (cnt_q >= CW'(LIMIT));
endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the MEM stage and a debug/loader port,
// with a CPU halt handshake so the debug side can own memory undisturbed.
module dmem_port_arbiter #(
    parameter int ADDR_W = mips_mem_pkg::DMEM_ADDR_W,
    parameter int DATA_W = mips_mem_pkg::DATA_W,
    parameter int STARVE_LIMIT = mips_mem_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    input  logic              dbg_hold,
    output logic              halted,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import mips_mem_pkg::*;

    arb_state_t state_q, state_d;
    logic cpu_rv_q, cpu_rv_d;
    logic dbg_ack_q, dbg_ack_d;
    logic dbg_rd_q, dbg_rd_d;

    logic gnt_cpu, gnt_dbg, ld_gnt;
    logic dbg_ok, starved, starve_inc;
    logic unused_addr;

    // Byte offset and high address bits carry no meaning for word memory.
    assign unused_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    // The ack cycle must not re-grant the still-held request.
    assign dbg_ok = dbg_req && !dbg_ack_q;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dbg = 1'b0;
        if (!reset) begin
            unique case (state_q)
                RUN, HALT_REQ: begin
                    if (starved && dbg_ok) begin
                        gnt_dbg = 1'b1;
                    end else if (cpu_req && !cpu_rv_q) begin
                        gnt_cpu = 1'b1;
                    end else if (dbg_ok) begin
                        gnt_dbg = 1'b1;
                    end
                end
                HALT: gnt_dbg = dbg_ok;
                default: ;
            endcase
        end
    end

    assign ld_gnt = gnt_cpu && !cpu_we;
    assign starve_inc = !reset && dbg_ok && !gnt_dbg;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (dbg_hold) state_d = HALT_REQ;
            end
            HALT_REQ: begin
                if (!dbg_hold) state_d = RUN;
                else if (!ld_gnt) state_d = HALT;
            end
            HALT: begin
                if (!dbg_hold) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_dbg) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (gnt_cpu) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr[ADDR_W+1:2];
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_rv_d  = ld_gnt;
    assign dbg_ack_d = gnt_dbg;
    assign dbg_rd_d  = gnt_dbg && !dbg_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cpu_rv_q  <= 1'b0;
            dbg_ack_q <= 1'b0;
            dbg_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_rv_q  <= cpu_rv_d;
            dbg_ack_q <= dbg_ack_d;
            dbg_rd_q  <= dbg_rd_d;
        end
    end

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (gnt_dbg),
        .starved(starved)
    );

    // A reset landing mid-transaction swallows the pending return pulses.
    assign cpu_rvalid = cpu_rv_q && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dbg_ack    = dbg_ack_q && !reset;
    assign dbg_rdata  = (dbg_ack && dbg_rd_q) ? mem_rdata : '0;
    assign halted     = (state_q == HALT) && !reset;
    assign cpu_stall  = !reset && ((cpu_req && !gnt_cpu && !cpu_rv_q) || ld_gnt);
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port RAM behind it.
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_rvalid, cpu_stall;
    logic        dbg_req, dbg_we;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        dbg_ack, dbg_hold, halted;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ram [256];

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [31:0] W1 = 32'h0fdf6e91;
    localparam logic [31:0] CA = 32'hffff_fc22;
    localparam logic [31:0] CD = 32'hcafe_0000;
    localparam logic [31:0] D3 = 32'h3333_3333;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .dbg_hold  (dbg_hold),
        .halted    (halted),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic rst, creq, cwe;
        logic [31:0] caddr, cwd;
        logic dreq, dwe;
        logic [7:0] daddr;
        logic [31:0] dwd;
        logic hold;
        logic st, rv;
        logic [31:0] rd;
        logic ack;
        logic [31:0] drd;
        logic hlt, en, we;
        logic [7:0] ad;
        logic [31:0] wd;
    } vec_t;

    vec_t vt [40];
    int nv = 0;

    task automatic add(
        input logic r, cr, cw, input logic [31:0] ca, cd,
        input logic dr, dw, input logic [7:0] da, input logic [31:0] dd, input logic h,
        input logic st, rv, input logic [31:0] rd, input logic ack, input logic [31:0] drd,
        input logic hlt, en, we, input logic [7:0] ad, input logic [31:0] wd);
        vt[nv] = '{r, cr, cw, ca, cd, dr, dw, da, dd, h, st, rv, rd, ack, drd, hlt, en, we, ad, wd};
        nv++;
    endtask

    task automatic drv(
        input logic r, cr, cw, input logic [31:0] ca, cd,
        input logic dr, dw, input logic [7:0] da, input logic [31:0] dd, input logic h);
        reset = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_hold = h;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [127:0] outs(input logic en_m, input logic we_m);
        return {18'h0, cpu_stall, cpu_rvalid, cpu_rdata, dbg_ack, dbg_rdata, halted,
                mem_en, mem_we, en_m ? mem_addr : 8'h0, we_m ? mem_wdata : 32'h0};
    endfunction

    function automatic logic [127:0] expv(input vec_t v);
        return {18'h0, v.st, v.rv, v.rd, v.ack, v.drd, v.hlt, v.en, v.we,
                v.en ? v.ad : 8'h0, (v.en && v.we) ? v.wd : 32'h0};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        // reset, with and without requests present
        add(1,0,0,0,0,   0,0,0,0,0,  0,0,0,0,0,   0,0,0,0,0);
        add(1,1,0,4,0,   1,0,1,0,1,  0,0,0,0,0,   0,0,0,0,0);
        // halt then preload words 0 and 1, read word 1 back
        add(0,0,0,0,0,   0,0,0,0,1,  0,0,0,0,0,   0,0,0,0,0);
        add(0,0,0,0,0,   0,0,0,0,1,  0,0,0,0,0,   0,0,0,0,0);
        add(0,0,0,0,0,   1,1,0,5,1,  0,0,0,0,0,   1,1,1,0,5);
        add(0,0,0,0,0,   1,1,0,5,1,  0,0,0,1,0,   1,0,0,0,0);
        add(0,0,0,0,0,   1,1,1,W1,1, 0,0,0,0,0,   1,1,1,1,W1);
        add(0,0,0,0,0,   1,1,1,W1,1, 0,0,0,1,0,   1,0,0,0,0);
        add(0,0,0,0,0,   1,0,1,0,1,  0,0,0,0,0,   1,1,0,1,0);
        add(0,0,0,0,0,   1,0,1,0,1,  0,0,0,1,W1,  1,0,0,0,0);
        add(0,0,0,0,0,   0,0,0,0,0,  0,0,0,0,0,   1,0,0,0,0);
        // lw byte 0x4 after release
        add(0,1,0,4,0,   0,0,0,0,0,  1,0,0,0,0,   0,1,0,1,0);
        add(0,1,0,4,0,   0,0,0,0,0,  0,1,W1,0,0,  0,0,0,0,0);
        add(0,0,0,0,0,   0,0,0,0,0,  0,0,0,0,0,   0,0,0,0,0);
        // debug read granted in the load-return cycle
        add(0,1,0,4,0,   0,0,0,0,0,  1,0,0,0,0,   0,1,0,1,0);
        add(0,1,0,4,0,   1,0,0,0,0,  0,1,W1,0,0,  0,1,0,0,0);
        add(0,0,0,0,0,   1,0,0,0,0,  0,0,0,1,5,   0,0,0,0,0);
        add(0,0,0,0,0,   0,0,0,0,0,  0,0,0,0,0,   0,0,0,0,0);
        // starvation: stores every cycle, debug write wins at cycle 4
        for (int i = 0; i < 4; i++)
            add(0,1,1,CA,CD, 1,1,3,D3,0, 0,0,0,0,0, 0,1,1,8,CD);
        add(0,1,1,CA,CD, 1,1,3,D3,0, 1,0,0,0,0,   0,1,1,3,D3);
        add(0,1,1,CA,CD, 1,1,3,D3,0, 0,0,0,1,0,   0,1,1,8,CD);
        add(0,0,0,0,0,   0,0,0,0,0,  0,0,0,0,0,   0,0,0,0,0);

        for (int i = 0; i < nv; i++) begin
            drv(vt[i].rst, vt[i].creq, vt[i].cwe, vt[i].caddr, vt[i].cwd,
                vt[i].dreq, vt[i].dwe, vt[i].daddr, vt[i].dwd, vt[i].hold);
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(vt[i].en, vt[i].en && vt[i].we), expv(vt[i]));
            step();
        end

        chk("ram0", {96'h0, ram[0]}, {96'h0, 32'h5});
        chk("ram3", {96'h0, ram[3]}, {96'h0, D3});
        chk("ram8", {96'h0, ram[8]}, {96'h0, CD});

        // same-cycle CPU and debug writes to word 9
        drv(0, 1, 1, 32'h24, 32'hd18fa600, 1, 1, 9, 32'h11111111, 0);
        @(negedge clk);
        chk("t4_cpu_wins", {mem_en, mem_we, cpu_stall, mem_addr, mem_wdata}, {3'b110, 8'd9, 32'hd18fa600});
        step();
        drv(0, 0, 0, 0, 0, 1, 1, 9, 32'h11111111, 0);
        @(negedge clk);
        chk("t4_ram_cpu", {96'h0, ram[9]}, {96'h0, 32'hd18fa600});
        chk("t4_dbg_gnt", {mem_en, mem_we, dbg_ack, mem_addr, mem_wdata}, {3'b110, 8'd9, 32'h11111111});
        step();
        @(negedge clk);
        chk("t4_ack", {dbg_ack, ram[9]}, {1'b1, 32'h11111111});
        step();
        idle();
        step();

        // halt requested in a load grant cycle
        drv(0, 1, 0, 4, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t5_ld_grant", {cpu_stall, mem_en, mem_we, halted}, 4'b1100);
        step();
        @(negedge clk);
        chk("t5_rvalid", {cpu_rvalid, cpu_rdata, cpu_stall, halted}, {1'b1, W1, 2'b00});
        step();
        drv(0, 1, 1, 32'h28, 32'habcd1234, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t5_halt%0d", i), {halted, cpu_stall, mem_en}, 3'b110);
            step();
        end
        dbg_hold = 1'b0;
        @(negedge clk);
        chk("t5_release", {halted, cpu_stall, mem_en}, 3'b110);
        step();
        @(negedge clk);
        chk("t5_run", {halted, cpu_stall, mem_en, mem_we, mem_addr}, {4'b0011, 8'd10});
        step();
        idle();
        step();
        chk("t5_ram10", {96'h0, ram[10]}, {96'h0, 32'habcd1234});

        // reset in the cycle after a load grant
        drv(0, 1, 0, 4, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_ld_grant", {cpu_stall, mem_en}, 2'b11);
        step();
        drv(1, 1, 0, 4, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_rst_cycle", outs(1'b1, 1'b1), 128'h0);
        step();
        idle();
        @(negedge clk);
        chk("t6_after", outs(1'b1, 1'b1), 128'h0);
        step();

        // reset in the cycle after a debug read grant
        drv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("t6_dbg_grant", {mem_en, mem_we, mem_addr}, {2'b10, 8'd1});
        step();
        drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("t6_dbg_rst", outs(1'b1, 1'b1), 128'h0);
        step();
        idle();
        @(negedge clk);
        chk("t6_dbg_after", outs(1'b1, 1'b1), 128'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
